// File: rtl/mac_acc_tc_16_if.sv
// rtl/mac_acc_tc_16_if.sv - product/result handshake bundle for mac_acc_tc_16
// master drives products and result acceptance; slave is the accumulator.
interface mac_acc_tc_16_if #(
  parameter int ACC_W = 40
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      product;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic [8:0]       out_count;
  logic             out_ovf;

  modport master (
    output in_valid, product, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_ovf
  );

  modport slave (
    input  in_valid, product, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_ovf
  );
endinterface

// File: rtl/mac_acc_tc_16.sv
// rtl/mac_acc_tc_16.sv - framed signed accumulator behind the 16x16 multiplier
// Optional MAC_SAT_EN clamps each frame sum to the signed 32-bit range and flags out_ovf.
module mac_acc_tc_16 #(
  parameter int ACC_W   = 40,
  parameter int N_TERMS = 8
) (
  input logic              clk,
  input logic              rst,
  mac_acc_tc_16_if.slave   bus
);
  typedef enum logic {ACC, HOLD} state_t;

  state_t                  state;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] res;
  logic [7:0]              cnt;
  logic                    accept;
  logic                    close;
  logic                    ovf;
  logic                    out_valid_q;
  logic [ACC_W-1:0]        out_data_q;
  logic [8:0]              out_count_q;
  logic                    out_ovf_q;

  assign bus.in_ready = (state == ACC) && !rst;
  assign accept       = bus.in_valid && bus.in_ready;
  assign sum          = acc + {{(ACC_W-32){bus.product[31]}}, bus.product};
  assign close        = (9'(cnt) == 9'(N_TERMS-1)) || bus.in_last;

`ifdef MAC_SAT_EN
  logic pos_ovf;
  logic neg_ovf;

  // The sum fits in 32 bits only when bits ACC_W-1 down to 31 all agree.
  assign pos_ovf = !sum[ACC_W-1] && (|sum[ACC_W-2:31]);
  assign neg_ovf =  sum[ACC_W-1] && !(&sum[ACC_W-2:31]);
  assign ovf     = pos_ovf || neg_ovf;
  assign res     = pos_ovf ? ACC_W'(32'h7fff_ffff) :
                   neg_ovf ? {{(ACC_W-31){1'b1}}, 31'd0} : sum;
`else
  assign ovf = 1'b0;
  assign res = sum;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ACC;
      acc         <= '0;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            if (close) begin
              out_data_q  <= res;
              out_count_q <= 9'(cnt) + 9'd1;
              out_ovf_q   <= ovf;
              out_valid_q <= 1'b1;
              acc         <= '0;
              cnt         <= '0;
              state       <= HOLD;
            end else begin
              acc <= sum;
              cnt <= cnt + 8'd1;
            end
          end
        end
        HOLD: begin
          // Result stays frozen until the consumer takes it.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;
  assign bus.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_mac_acc_tc_16.sv
// tb/tb_mac_acc_tc_16.sv - directed plus random bench for mac_acc_tc_16
module tb_mac_acc_tc_16;
  localparam int ACC_W   = 40;
  localparam int N_TERMS = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  mac_acc_tc_16_if #(.ACC_W(ACC_W)) bus ();

  mac_acc_tc_16 #(.ACC_W(ACC_W), .N_TERMS(N_TERMS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: frame sum as a plain 64-bit integer, closed by count or in_last.
  bit         m_hold = 1'b0;
  longint     m_sum  = 0;
  int         m_cnt  = 0;
  logic [ACC_W-1:0] m_data  = '0;
  logic [8:0] m_count = '0;
  logic       m_ovf   = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic close_frame();
    longint s = m_sum;
    m_ovf = 1'b0;
`ifdef MAC_SAT_EN
    if (s > 64'sd2147483647) begin s = 64'sd2147483647; m_ovf = 1'b1; end
    else if (s < -64'sd2147483648) begin s = -64'sd2147483648; m_ovf = 1'b1; end
`endif
    m_data  = ACC_W'(s);
    m_count = 9'(m_cnt);
    m_hold  = 1'b1;
    m_sum   = 0;
    m_cnt   = 0;
  endtask

  // One clock: drive, check outputs against the model at negedge, advance model at posedge.
  task automatic step(input logic v, input logic [31:0] p, input logic l,
                      input logic ordy, input logic r);
    rst           = r;
    bus.in_valid  = v;
    bus.product   = p;
    bus.in_last   = l;
    bus.out_ready = ordy;
    @(negedge clk);
    chk("in_ready",  64'(bus.in_ready),  64'(!r && !m_hold));
    chk("out_valid", 64'(bus.out_valid), 64'(m_hold));
    chk("out_data",  64'(bus.out_data),  64'(m_data));
    chk("out_count", 64'(bus.out_count), 64'(m_count));
    chk("out_ovf",   64'(bus.out_ovf),   64'(m_ovf));
    @(posedge clk);
    if (r) begin
      m_hold = 1'b0; m_sum = 0; m_cnt = 0;
      m_data = '0; m_count = '0; m_ovf = 1'b0;
    end else if (!m_hold && v) begin
      m_sum = m_sum + longint'(signed'(p));
      m_cnt++;
      if (m_cnt == N_TERMS || l) close_frame();
    end else if (m_hold && ordy) begin
      m_hold = 1'b0;
    end
    #1;
  endtask

  task automatic expect_result(input string tag, input logic [ACC_W-1:0] d,
                               input logic [8:0] c, input logic o);
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'(1));
    chk({tag, "_data"},  64'(bus.out_data),  64'(d));
    chk({tag, "_count"}, 64'(bus.out_count), 64'(c));
    chk({tag, "_ovf"},   64'(bus.out_ovf),   64'(o));
  endtask

  initial begin
    logic [ACC_W-1:0] e2, e6;
    logic             o2, o6;
`ifdef MAC_SAT_EN
    e2 = 40'hFF_8000_0000; o2 = 1'b1;
    e6 = 40'h00_7FFF_FFFF; o6 = 1'b1;
`else
    e2 = 40'hFE_0000_0000; o2 = 1'b0;
    e6 = 40'h02_0000_0000; o6 = 1'b0;
`endif
    bus.in_valid = 1'b0; bus.product = '0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);

    // 1: eight beats of 3, one bubble per frame
    for (int i = 0; i < 8; i++) step(1, 32'd3, 0, 1, 0);
    expect_result("t1", 40'd24, 9'd8, 1'b0);
    step(1, 32'd5, 0, 1, 0);
    chk("t1_bubble_over", 64'(bus.in_ready), 64'(1));

    // 2: -2^30 x8
    for (int i = 0; i < 8; i++) step(1, 32'hC000_0000, 0, 1, 0);
    expect_result("t2", e2, 9'd8, o2);
    step(0, 0, 0, 1, 0);

    // 3: early close with in_last
    step(1, 32'd100, 0, 1, 0);
    step(1, 32'hFFFF_FF06, 0, 1, 0);
    step(1, 32'd7, 1, 1, 0);
    expect_result("t3", 40'hFF_FFFF_FF71, 9'd3, 1'b0);
    step(0, 0, 0, 1, 0);
    step(1, 32'd9, 1, 1, 0);
    expect_result("t3_fresh", 40'd9, 9'd1, 1'b0);
    step(0, 0, 0, 1, 0);

    // 4: consumer stalls five cycles while products are offered
    for (int i = 0; i < 8; i++) step(1, 32'(i * 11), 0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 32'd77, 1, 0, 0);
    expect_result("t4", 40'd308, 9'd8, 1'b0);
    step(1, 32'd77, 0, 1, 0);
    step(0, 0, 0, 1, 0);

    // 5: reset mid-frame discards partial sum
    for (int i = 0; i < 4; i++) step(1, 32'd1000, 0, 1, 0);
    step(1, 32'd1000, 0, 1, 1);
    chk("t5_rst_data", 64'(bus.out_data), 64'(0));
    for (int i = 0; i < 8; i++) step(1, 32'd1, 0, 1, 0);
    expect_result("t5", 40'd8, 9'd8, 1'b0);
    step(0, 0, 0, 1, 0);

    // 6: gapped beats, in_last only on idle cycles
    for (int i = 0; i < 8; i++) begin
      step(1, 32'h4000_0000, 0, 1, 0);
      if (i < 7) begin
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 1, 0);
      end
    end
    expect_result("t6", e6, 9'd8, o6);
    step(0, 0, 0, 1, 0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [31:0] p;
      p = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($signed($urandom_range(0, 2000)) - 1000);
      step($urandom_range(0, 1) == 1, p, $urandom_range(0, 7) == 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
